// File: rtl/riscv_pkg.sv
// riscv_pkg: load/store encodings, LSU state type and alignment helper
package riscv_pkg;
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3 == LS_B || f3 == LS_BU) ? 1'b0 :
           (f3 == LS_H || f3 == LS_HU) ? a[0] :
           (f3 == LS_W) ? |a : 1'b1;
  endfunction
endpackage

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: req/ack data-memory bus between LSU (master) and memory (slave)
interface lsu_mem_stage_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/half of a read word and sign/zero-extends it
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = 8'(rdata >> {addr, 3'b000});
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    data = funct3 == LS_B  ? {{24{b[7]}}, b} :
           funct3 == LS_BU ? {24'b0, b} :
           funct3 == LS_H  ? {{16{h[15]}}, h} :
           funct3 == LS_HU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit driving a multi-cycle req/ack data bus
module lsu_mem_stage
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead_m,
  input  logic              MemWrite_m,
  input  logic [2:0]        funct3_m,
  input  logic [ADDR_W-1:0] ALUResult_m,
  input  logic [DATA_W-1:0] WriteData_m,
  input  logic              kill_m,
  lsu_mem_stage_if.master   bus,
  output logic [DATA_W-1:0] ReadData_m,
  output logic              lsu_stall,
  output logic              misalign_fault
);
  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, a;
  logic [2:0]        f3_q, f3_d, f3;
  logic              we_q, we_d, kill_q, kill_d, we;
  logic [DATA_W-1:0] wd_q, wd_d, rdata_q, rdata_d, wd, ext;
  logic              busy, acc, fault, issue, req, on;
  lsu_load_align u_align (.rdata(rdata_q), .funct3(f3_q), .addr(addr_q[1:0]), .data(ext));
  always_comb begin
    busy = state_q == BUSY;
    acc = state_q == IDLE && (MemRead_m || MemWrite_m) && !kill_m;
    fault = acc && (is_misaligned(funct3_m, ALUResult_m[1:0]) || (MemWrite_m && funct3_m[2]));
    issue = acc && !fault;
    req = issue || busy;
    on = req && rst_n;
    // BUSY replays the access from the copy taken at issue
    a = busy ? addr_q : ALUResult_m;
    f3 = busy ? f3_q : funct3_m;
    we = busy ? we_q : MemWrite_m;
    wd = busy ? wd_q : WriteData_m;
    state_d = (req && bus.mem_ack) ? DONE : req ? BUSY : IDLE;
    addr_d = issue ? ALUResult_m : addr_q;
    f3_d = issue ? funct3_m : f3_q;
    we_d = issue ? MemWrite_m : we_q;
    wd_d = issue ? WriteData_m : wd_q;
    kill_d = issue ? 1'b0 : (kill_q || (busy && kill_m));
    rdata_d = (req && bus.mem_ack) ? bus.mem_rdata : rdata_q;
    bus.mem_req = on;
    bus.mem_we = on && we;
    bus.mem_addr = on ? {a[ADDR_W-1:2], 2'b00} : '0;
    bus.mem_be = !on ? 4'h0 : !we ? 4'hF :
                 f3[1:0] == 2'b00 ? 4'b0001 << a[1:0] :
                 f3[1:0] == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'hF;
    bus.mem_wdata = !(on && we) ? '0 :
                    f3[1:0] == 2'b00 ? {4{wd[7:0]}} :
                    f3[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
    lsu_stall = on;
    misalign_fault = fault && rst_n;
    ReadData_m = (rst_n && state_q == DONE && !we_q && !kill_q && !kill_m) ? ext : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      f3_q <= '0;
      we_q <= 1'b0;
      kill_q <= 1'b0;
      wd_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      f3_q <= f3_d;
      we_q <= we_d;
      kill_q <= kill_d;
      wd_q <= wd_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed and randomized accesses checked against a transaction-level model
module tb_lsu_mem_stage;
  import riscv_pkg::*;
  logic clk = 0, rst_n = 0, MemRead_m = 0, MemWrite_m = 0, kill_m = 0;
  logic [2:0] funct3_m = 0;
  logic [31:0] ALUResult_m = 0, WriteData_m = 0, ReadData_m;
  logic lsu_stall, misalign_fault;
  lsu_mem_stage_if bus ();
  lsu_mem_stage dut (.clk(clk), .rst_n(rst_n), .MemRead_m(MemRead_m), .MemWrite_m(MemWrite_m),
    .funct3_m(funct3_m), .ALUResult_m(ALUResult_m), .WriteData_m(WriteData_m), .kill_m(kill_m),
    .bus(bus), .ReadData_m(ReadData_m), .lsu_stall(lsu_stall), .misalign_fault(misalign_fault));
  always #5 clk = ~clk;

  int errors = 0, checks = 0, stall_cnt;
  bit exp_valid = 0, exp_req, exp_stall, exp_fault, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rd, last_rd, last_addr, last_wdata;
  logic [3:0] exp_be, last_be;
  logic last_fault;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) if (exp_valid) begin
    chk("mem_req", 32'(bus.mem_req), 32'(exp_req));
    chk("lsu_stall", 32'(lsu_stall), 32'(exp_stall));
    chk("misalign_fault", 32'(misalign_fault), 32'(exp_fault));
    chk("ReadData_m", ReadData_m, exp_rd);
    if (exp_req) begin
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("mem_be", 32'(bus.mem_be), 32'(exp_be));
      chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
      if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
    end
  end

  function automatic bit m_fault(int kind, logic [2:0] f3, logic [31:0] a);
    if (kind == 0) return 0;
    if (f3 == 0 || (kind == 1 && f3 == 4)) return 0;
    if (f3 == 1 || (kind == 1 && f3 == 5)) return a[0];
    if (f3 == 2) return a[1:0] != 0;
    return 1;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] word);
    logic [31:0] byt, hw;
    byt = (word >> (int'(a[1:0]) * 8)) & 32'hFF;
    hw = (word >> (int'(a[1]) * 16)) & 32'hFFFF;
    case (f3)
      3'd0: return byt[7] ? byt | 32'hFFFFFF00 : byt;
      3'd4: return byt;
      3'd1: return hw[15] ? hw | 32'hFFFF0000 : hw;
      3'd5: return hw;
      default: return word;
    endcase
  endfunction

  task automatic set_exp(bit req, bit flt, logic [31:0] rd);
    exp_req = req; exp_stall = req; exp_fault = flt; exp_rd = rd;
  endtask

  // one instruction: kind 0 none, 1 load, 2 store; kill = squash while waiting, kidle = squash at issue
  task automatic run(int kind, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, logic [31:0] word,
                     int waits, bit kill, bit kidle);
    bit flt = m_fault(kind, f3, a);
    exp_valid = 1;
    stall_cnt = 0;
    exp_addr = {a[31:2], 2'b00};
    exp_we = kind == 2;
    exp_be = kind == 1 ? 4'hF : f3 == 0 ? 4'(1 << a[1:0]) : f3 == 1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'hF;
    exp_wdata = f3 == 0 ? {4{wd[7:0]}} : f3 == 1 ? {2{wd[15:0]}} : wd;
    @(posedge clk); #1;
    MemRead_m = kind == 1; MemWrite_m = kind == 2; funct3_m = f3;
    ALUResult_m = a; WriteData_m = wd; kill_m = kidle;
    if (kind == 0 || kidle || flt) begin
      bus.mem_ack = 1'($urandom); bus.mem_rdata = $urandom;
      set_exp(0, kind != 0 && !kidle, 0);
      @(negedge clk);
      last_fault = misalign_fault;
      return;
    end
    for (int k = 0; k <= waits; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      kill_m = kill && k > 0;
      bus.mem_ack = k == waits;
      bus.mem_rdata = k == waits ? word : $urandom;
      set_exp(1, 0, 0);
      @(negedge clk);
      stall_cnt += int'(lsu_stall);
      if (k == 0) begin last_addr = bus.mem_addr; last_be = bus.mem_be; last_wdata = bus.mem_wdata; end
    end
    @(posedge clk); #1;
    bus.mem_ack = 1'($urandom); bus.mem_rdata = $urandom; kill_m = kill;
    set_exp(0, 0, (kind == 1 && !kill) ? m_load(f3, a, word) : 0);
    @(negedge clk);
    stall_cnt += int'(lsu_stall);
    last_rd = ReadData_m;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bus.mem_ack = 0; bus.mem_rdata = 0;
    MemRead_m = 1; funct3_m = 3'd3; ALUResult_m = 32'h100;
    @(negedge clk);
    chk("rst_fault", 32'(misalign_fault), 0);
    chk("rst_req", 32'(bus.mem_req), 0);
    funct3_m = LS_W;
    #1;
    chk("rst_req_w", 32'(bus.mem_req), 0);
    chk("rst_stall", 32'(lsu_stall), 0);
    chk("rst_rd", ReadData_m, 0);
    @(posedge clk); #1 rst_n = 1;
    bus.mem_ack = 0;
    @(negedge clk);
    chk("pre_busy_req", 32'(bus.mem_req), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_req", 32'(bus.mem_req), 1);
    chk("busy_stall", 32'(lsu_stall), 1);
    #1 rst_n = 0;
    #1;
    chk("async_rst_req", 32'(bus.mem_req), 0);
    chk("async_rst_stall", 32'(lsu_stall), 0);
    MemRead_m = 0;
    @(posedge clk); #1 rst_n = 1;
    run(1, LS_W, 32'h100, 0, 32'hDEADBEEF, 3, 0, 0);
    chk("lw_rd", last_rd, 32'hDEADBEEF);
    chk("lw_stall_cycles", 32'(stall_cnt), 4);
    chk("lw_addr", last_addr, 32'h100);
    chk("lw_be", 32'(last_be), 32'hF);
    run(1, LS_B, 32'h103, 0, 32'h80FF7F01, 1, 0, 0);
    chk("lb_rd", last_rd, 32'hFFFFFF80);
    run(1, LS_BU, 32'h103, 0, 32'h80FF7F01, 0, 0, 0);
    chk("lbu_rd", last_rd, 32'h00000080);
    run(1, LS_H, 32'h102, 0, 32'h80FF7F01, 2, 0, 0);
    chk("lh_rd", last_rd, 32'hFFFF80FF);
    run(1, LS_HU, 32'h100, 0, 32'h80FF7F01, 0, 0, 0);
    chk("lhu_rd", last_rd, 32'h00007F01);
    run(2, LS_B, 32'h201, 32'h123456AB, 0, 1, 0, 0);
    chk("sb_be", 32'(last_be), 32'b0010);
    chk("sb_wdata", last_wdata, 32'hABABABAB);
    chk("sb_addr", last_addr, 32'h200);
    run(2, LS_H, 32'h202, 32'h123456AB, 0, 0, 0, 0);
    chk("sh_be", 32'(last_be), 32'b1100);
    chk("sh_wdata", last_wdata, 32'h56AB56AB);
    chk("sh_stall_cycles", 32'(stall_cnt), 1);
    run(1, LS_W, 32'h102, 0, 0, 0, 0, 0);
    chk("lw_mis_fault", 32'(last_fault), 1);
    run(2, LS_H, 32'h301, 32'h5, 0, 0, 0, 0);
    chk("sh_mis_fault", 32'(last_fault), 1);
    run(1, 3'd3, 32'h100, 0, 0, 0, 0, 0);
    chk("f3_011_fault", 32'(last_fault), 1);
    run(1, LS_W, 32'h100, 0, 32'hCAFEF00D, 3, 1, 0);
    chk("kill_rd", last_rd, 0);
    chk("kill_stall_cycles", 32'(stall_cnt), 4);
    run(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [2:0] f3 = $urandom_range(0, 3) != 0 ? legal[$urandom_range(0, 4)] : 3'($urandom);
      run($urandom_range(0, 2), f3, $urandom, $urandom, $urandom, $urandom_range(0, 3),
          $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
    end
    exp_valid = 0;
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
